store_controller_n: RTL and testbench

Parametrised store sequencer for the multicore memory subsystem. It collects end-of-operation flags from a configurable set of cores. Once every participating core has finished, it sequences a write-back of NUM_ROWS register rows into data memory, driving the switch enable, memory write strobes and row addresses. It stalls on a memory-ready handshake and reports completion with a one-cycle pulse.

---
 rtl/store_controller_n.sv | 165 ++++++++++++++++
 tb/tb_store_controller_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/store_controller_n.sv
// Store sequencer: gathers per-core op-end flags, then writes NUM_ROWS rows to data memory.
// Optional watchdog enabled by defining STORE_TIMEOUT_EN.
module store_controller_n #(
    parameter int NUM_CORES      = 4,
    parameter int ROW_BITS       = 4,
    parameter int NUM_ROWS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] op_end,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic                 mem_ready,
    output logic                 memWrite,
    output logic                 swEnable,
    output logic                 memWrtoReg,
    output logic [ROW_BITS-1:0]  rowaddr,
    output logic [NUM_ROWS-1:0]  rowaddrtoSw,
    output logic                 store_busy,
    output logic                 store_done,
    output logic                 timeout_err
);

    if (NUM_ROWS < 1 || NUM_ROWS > (1 << ROW_BITS)) begin : g_bad_rows
        $error("store_controller_n: NUM_ROWS must lie in 1..2**ROW_BITS");
    end
    if (TIMEOUT_CYCLES < 1 || NUM_CORES < 1) begin : g_bad_cfg
        $error("store_controller_n: TIMEOUT_CYCLES and NUM_CORES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] flags_q, flags_d;
    logic [ROW_BITS-1:0]  row_q,   row_d;
    logic                 all_in;
    logic                 last_row;
    logic                 wd_fire;

    assign all_in   = (core_mask != '0) && ((flags_q & core_mask) == core_mask);
    assign last_row = (row_q == ROW_BITS'(NUM_ROWS - 1));

`ifdef STORE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;
    logic            any_in;

    assign any_in  = |(flags_q & core_mask);
    // Counter value N means N edges have passed since the first masked capture.
    assign wd_fire = any_in && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d   = wd_q;
        terr_d = terr_q;
        case (state_q)
            S_IDLE: begin
                if (all_in) begin
                    wd_d = '0;
                end else if (wd_fire) begin
                    wd_d   = '0;
                    terr_d = 1'b1;
                end else if (any_in) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE:  terr_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                flags_d = flags_q | op_end;
                if (all_in || wd_fire) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                row_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (last_row) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                flags_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            row_q   <= row_d;
        end
    end

    // Outputs decode only registered state, so reset clears them without a clock.
    always_comb begin
        memWrite    = 1'b0;
        swEnable    = 1'b0;
        memWrtoReg  = 1'b0;
        rowaddr     = '0;
        rowaddrtoSw = '0;
        store_done  = 1'b0;
        case (state_q)
            S_ARM: begin
                swEnable    = 1'b1;
                rowaddrtoSw = NUM_ROWS'(1);
            end
            S_WRITE: begin
                swEnable    = 1'b1;
                memWrite    = 1'b1;
                memWrtoReg  = 1'b1;
                rowaddr     = row_q;
                rowaddrtoSw = NUM_ROWS'(1) << row_q;
            end
            S_DONE:  store_done = 1'b1;
            default: ;
        endcase
    end

    assign store_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_store_controller_n.sv
// Self-checking bench for store_controller_n (default build, watchdog macro undefined).
module tb_store_controller_n;

    localparam int NC = 4;
    localparam int RB = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NC-1:0] op_end = '0;
    logic [NC-1:0] core_mask = '0;
    logic          mem_ready = 1'b1;
    logic          memWrite, swEnable, memWrtoReg;
    logic [RB-1:0] rowaddr;
    logic [NR-1:0] rowaddrtoSw;
    logic          store_busy, store_done, timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model: m_stage -1 = settle cycle, 0..NR-1 = row being written, NR = completion.
    bit            m_in    = 1'b0;
    int            m_stage = 0;
    logic [NC-1:0] m_flags = '0;

    store_controller_n #(
        .NUM_CORES(NC),
        .ROW_BITS(RB),
        .NUM_ROWS(NR),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op_end(op_end),
        .core_mask(core_mask),
        .mem_ready(mem_ready),
        .memWrite(memWrite),
        .swEnable(swEnable),
        .memWrtoReg(memWrtoReg),
        .rowaddr(rowaddr),
        .rowaddrtoSw(rowaddrtoSw),
        .store_busy(store_busy),
        .store_done(store_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit sw, wr, dn;
        int r;
        sw = m_in && (m_stage < NR);
        wr = m_in && (m_stage >= 0) && (m_stage < NR);
        dn = m_in && (m_stage == NR);
        r  = wr ? m_stage : 0;
        chk("store_busy",  32'(store_busy),  32'(m_in));
        chk("swEnable",    32'(swEnable),    32'(sw));
        chk("memWrite",    32'(memWrite),    32'(wr));
        chk("memWrtoReg",  32'(memWrtoReg),  32'(wr));
        chk("rowaddr",     32'(rowaddr),     32'(r));
        chk("rowaddrtoSw", 32'(rowaddrtoSw), sw ? (32'(1) << r) : 32'(0));
        chk("store_done",  32'(store_done),  32'(dn));
        chk("timeout_err", 32'(timeout_err), 32'(0));
    endtask

    task automatic model_edge();
        if (!m_in) begin
            if (core_mask != '0 && (m_flags & core_mask) == core_mask) begin
                m_in    = 1'b1;
                m_stage = -1;
            end
            m_flags = m_flags | op_end;
        end else if (m_stage < NR) begin
            if (m_stage < 0 || mem_ready) m_stage++;
        end else begin
            m_in    = 1'b0;
            m_flags = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Called at posedge+1; asserts reset between edges and releases it before the next edge.
    task automatic do_reset();
        #1 rst = 1'b1;
        m_in    = 1'b0;
        m_flags = '0;
        m_stage = 0;
        #1 check_outputs();
        #3 rst = 1'b0;
    endtask

    task automatic run_round(input int budget, input bit stall, input int exp_busy, input string tag);
        int  b, d, s3, s15;
        bit  started, finished;
        b = 0; d = 0; s3 = 0; s15 = 0;
        started = 1'b0; finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            mem_ready = 1'b1;
            if (stall && m_in && m_stage == 3 && s3 < 2) begin
                mem_ready = 1'b0;
                s3++;
            end
            if (stall && m_in && m_stage == 15 && s15 < 2) begin
                mem_ready = 1'b0;
                s15++;
            end
            tick();
            if (store_busy) begin
                b++;
                started = 1'b1;
            end
            if (store_done) d++;
            if (started && !store_busy) begin
                finished = 1'b1;
                break;
            end
        end
        mem_ready = 1'b1;
        chk({tag, "_complete"},   32'(finished), 32'(1));
        chk({tag, "_busy_cycles"}, 32'(b),       32'(exp_busy));
        chk({tag, "_done_pulses"}, 32'(d),       32'(1));
    endtask

    task automatic pulse_cores(input logic [NC-1:0] first, input logic [NC-1:0] second,
                               input logic [NC-1:0] third, input logic [NC-1:0] fourth);
        logic [NC-1:0] seq [4];
        seq[0] = first; seq[1] = second; seq[2] = third; seq[3] = fourth;
        for (int k = 0; k < 4; k++) begin
            op_end = seq[k];
            tick();
            op_end = '0;
            if (k < 3) begin
                tick();
                tick();
            end
        end
    endtask

    initial begin
        int d;
        core_mask = 4'b1111;
        #2 rst = 1'b1;
        #1 check_outputs();
        #9 rst = 1'b0;

        for (int i = 0; i < 50; i++) tick();

        pulse_cores(4'b0001, 4'b0100, 4'b1000, 4'b0010);
        run_round(60, 1'b0, NR + 2, "pulse_round");

        pulse_cores(4'b0001, 4'b0100, 4'b1000, 4'b0010);
        run_round(80, 1'b1, NR + 6, "stall_round");

        core_mask = 4'b0101;
        op_end = 4'b0001; tick();
        op_end = 4'b0100; tick();
        op_end = '0;
        run_round(60, 1'b0, NR + 2, "mask0101_round");

        core_mask = '0;
        op_end = 4'b1111;
        for (int i = 0; i < 30; i++) tick();
        op_end = '0;
        do_reset();

        core_mask = 4'b1111;
        op_end = 4'b0001; tick();
        op_end = '0;
        for (int i = 0; i < 40; i++) tick();
        do_reset();

        op_end = 4'b1111; tick();
        op_end = '0;
        for (int i = 0; i < 30 && !(m_in && m_stage == 7); i++) tick();
        chk("reached_row7", 32'(rowaddr), 32'(7));
        do_reset();
        d = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (store_done) d++;
        end
        chk("abandoned_done_pulses", 32'(d), 32'(0));
        op_end = 4'b1111; tick();
        op_end = '0;
        run_round(60, 1'b0, NR + 2, "post_reset_round");

        for (int i = 0; i < 600; i++) begin
            if (!m_in && $urandom_range(0, 15) == 0) core_mask = 4'($urandom_range(0, 15));
            op_end    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
